hub75_scanout: RTL

Parametrised display-side scan engine for HUB75 panels: reads a double-buffered framebuffer through a one-cycle-latency read port and drives a 1/(HEIGHT/2)-scan panel using binary-coded modulation (BCM). It has programmable colour depth, panel geometry and global brightness. Buffer swaps are frame-synchronous. It replaces the fixed 64x32, 4-bit scan logic and sits between the framebuffer RAM and the panel connector.

---
 rtl/hub75_pkg.sv | 47 ++++
 rtl/hub75_bcm_timer.sv | 36 +++
 rtl/hub75_scanout.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared states, geometry widths and {R,G,B}
// field extractors for the HUB75 scan engine.
package hub75_pkg;

  typedef enum logic [1:0] {
    SHIFT,
    LATCH,
    DEAD,
    SHOW
  } state_e;

  // Widths for the default 64x32 panel; the top derives
  // its own from its parameters.
  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_HEIGHT = 32;
  localparam int unsigned ROW_BITS   = $clog2(DEF_HEIGHT / 2);
  localparam int unsigned COL_BITS   = $clog2(DEF_WIDTH);

  // w holds a zero-extended {R,G,B} word of 3*d bits.
  function automatic logic [7:0] get_r(
    input logic [23:0] w,
    input int unsigned d
  );
    logic [23:0] m;
    m = (24'd1 << d) - 24'd1;
    return 8'((w >> (2 * d)) & m);
  endfunction

  function automatic logic [7:0] get_g(
    input logic [23:0] w,
    input int unsigned d
  );
    logic [23:0] m;
    m = (24'd1 << d) - 24'd1;
    return 8'((w >> d) & m);
  endfunction

  function automatic logic [7:0] get_b(
    input logic [23:0] w,
    input int unsigned d
  );
    logic [23:0] m;
    m = (24'd1 << d) - 24'd1;
    return 8'(w & m);
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: loadable down-counter for SHOW/DEAD.
// Ports: clk, n_reset, load_i, val_i -> done_o (last cycle).
module hub75_bcm_timer #(
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the final cycle of a loaded interval.
  assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/hub75_scanout.sv
// hub75_scanout: BCM scan engine, double-buffered FB -> HUB75.
// Ports: clk/n_reset, brightness, swap_req, fb_rd_* port,
// fb_select/swap_done/frame_start, hub75_* panel pins.
// Option: HUB75_DEADTIME_EN inserts DEAD after each LATCH.
module hub75_scanout
  import hub75_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned HEIGHT   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEADTIME = 2
) (
  input  logic                                   clk,
  input  logic                                   n_reset,
  input  logic [7:0]                             brightness,
  input  logic                                   swap_req,
  output logic [$clog2(HEIGHT)+$clog2(WIDTH):0]  fb_rd_addr,
  input  logic [3*DEPTH-1:0]                     fb_rd_data,
  output logic                                   fb_select,
  output logic                                   swap_done,
  output logic                                   frame_start,
  output logic [1:0]                             hub75_red,
  output logic [1:0]                             hub75_green,
  output logic [1:0]                             hub75_blue,
  output logic [$clog2(HEIGHT/2)-1:0]            hub75_addr,
  output logic                                   hub75_clk,
  output logic                                   hub75_latch,
  output logic                                   hub75_oe
);

  localparam int unsigned RB = $clog2(HEIGHT / 2);
  localparam int unsigned CB = $clog2(WIDTH);
  localparam int unsigned CW = 8 + DEPTH;
`ifdef HUB75_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif
  localparam int unsigned DT = DEAD_EN ? DEADTIME : 0;

  state_e        st_q;
  state_e        nxt;
  logic          run_q;
  logic [1:0]    ph_q;
  logic [CB-1:0] col_q;
  logic [RB-1:0] row_q;
  logic [RB-1:0] addr_q;
  logic [2:0]    pl_q;
  logic          sel_q;
  logic          swap_done_q;
  logic [7:0]    bq_q;
  logic [2:0]    top_q;
  logic [1:0]    red_q;
  logic [1:0]    grn_q;
  logic [1:0]    blu_q;

  logic [23:0]   word;
  logic [7:0]    r_f;
  logic [7:0]    g_f;
  logic [7:0]    b_f;
  logic [2:0]    cur;
  logic [CW-1:0] show_len;
  logic [CW-1:0] t_val;
  logic          t_load;
  logic          t_done;
  logic          go_next;
  logic          last_col;
  logic          last_pl;
  logic          last_row;
  logic          live;

  assign word = 24'(fb_rd_data);
  assign r_f  = get_r(word, DEPTH);
  assign g_f  = get_g(word, DEPTH);
  assign b_f  = get_b(word, DEPTH);
  // Current plane's bit of the word on the read port.
  assign cur  = {r_f[pl_q], g_f[pl_q], b_f[pl_q]};

  assign show_len = CW'(bq_q) << pl_q;
  assign last_col = (col_q == CB'(WIDTH - 1));
  assign last_pl  = (pl_q == 3'(DEPTH - 1));
  assign last_row = (row_q == RB'(HEIGHT / 2 - 1));

  always_comb begin
    nxt     = st_q;
    go_next = 1'b0;
    case (st_q)
      SHIFT: begin
        if (ph_q == 2'd3 && last_col) nxt = LATCH;
      end
      LATCH: begin
        if (DT != 0) nxt = DEAD;
        else if (show_len != '0) nxt = SHOW;
        else go_next = 1'b1;
      end
      DEAD: begin
        if (t_done) begin
          if (show_len != '0) nxt = SHOW;
          else go_next = 1'b1;
        end
      end
      SHOW: begin
        if (t_done) go_next = 1'b1;
      end
      default: nxt = SHIFT;
    endcase
  end

  // LATCH loads DEAD or SHOW length; DEAD hands over to SHOW.
  assign t_load = (st_q == LATCH) || (st_q == DEAD && t_done);
  assign t_val  = (st_q == LATCH && DT != 0) ? CW'(DT) : show_len;

  hub75_bcm_timer #(
    .CW (CW)
  ) u_timer (
    .clk     (clk),
    .n_reset (n_reset),
    .load_i  (t_load),
    .val_i   (t_val),
    .done_o  (t_done)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      st_q        <= SHIFT;
      run_q       <= 1'b0;
      ph_q        <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      pl_q        <= 3'd0;
      sel_q       <= 1'b0;
      swap_done_q <= 1'b0;
      bq_q        <= 8'd0;
      top_q       <= 3'd0;
      red_q       <= 2'd0;
      grn_q       <= 2'd0;
      blu_q       <= 2'd0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      swap_done_q <= 1'b0;
      if (frame_start) bq_q <= brightness;
      if (st_q == SHIFT) begin
        ph_q <= ph_q + 2'd1;
        if (ph_q == 2'd1) top_q <= cur;
        if (ph_q == 2'd2) begin
          red_q <= {cur[2], top_q[2]};
          grn_q <= {cur[1], top_q[1]};
          blu_q <= {cur[0], top_q[0]};
        end
        if (ph_q == 2'd3) begin
          col_q <= col_q + 1'b1;
          if (last_col) addr_q <= row_q;
        end
      end
      if (go_next) begin
        st_q <= SHIFT;
        pl_q <= last_pl ? 3'd0 : pl_q + 3'd1;
        if (last_pl) begin
          row_q <= row_q + 1'b1;
          if (last_row && swap_req) begin
            sel_q       <= ~sel_q;
            swap_done_q <= 1'b1;
          end
        end
      end else begin
        st_q <= nxt;
      end
    end
  end

  // Bottom pixel bit arrives on the read port during phase 2.
  assign live = (st_q == SHIFT) && (ph_q == 2'd2);

  assign hub75_red   = live ? {cur[2], top_q[2]} : red_q;
  assign hub75_green = live ? {cur[1], top_q[1]} : grn_q;
  assign hub75_blue  = live ? {cur[0], top_q[0]} : blu_q;
  assign hub75_addr  = addr_q;
  assign hub75_clk   = (st_q == SHIFT) && (ph_q == 2'd3);
  assign hub75_latch = (st_q == LATCH);
  assign hub75_oe    = (st_q != SHOW);
  assign fb_select   = sel_q;
  assign swap_done   = swap_done_q;
  assign fb_rd_addr  = {sel_q, ph_q == 2'd1, row_q, col_q};
  assign frame_start = run_q && (st_q == SHIFT) && (ph_q == 2'd0)
                       && (col_q == '0) && (row_q == '0)
                       && (pl_q == 3'd0);

endmodule
